shift_add_mul_ctrl: RTL

//   Sequential 32x32->64 unsigned multiplier built around a single 32-bit ripple_carry_adder.

---
 rtl/mul_pkg.sv | 16 +
 rtl/ripple_carry_adder.sv | 30 +++
 rtl/shift_add_mul_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t : FSM encoding (IDLE/RUN/DONE)
//   MUL_W   : operand width the adder datapath is built for
//   CNT_W   : width of the step counter (holds 0..32)
package mul_pkg;

  localparam int MUL_W = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder.
//   a, b : addends (W bits)
//   c0   : carry in
//   sum  : W-bit sum
//   cout : carry out of the top bit
module ripple_carry_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c0,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c0;
    for (int i = 0; i < W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

  assign cout = carry[W];

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequential 32x32->64 unsigned multiplier, one shift-add step per cycle
// through a single 32-bit ripple-carry adder.
//
// Handshakes: an operand pair transfers on a rising edge where
// start_valid && start_ready; a product transfers on a rising edge where
// res_valid && res_ready. start_ready is high only in IDLE, res_valid only
// in DONE, so the two sides never overlap in one cycle.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start_valid/ready   operand handshake
//   op_a, op_b          multiplicand, multiplier
//   abort               cancel the operation in RUN or DONE (wins over res handshake)
//   res_valid/ready     result handshake
//   product             64-bit result, only updated when entering DONE
//   busy                high whenever not IDLE
module shift_add_mul_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               abort,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_t             state, state_next;
  logic [2*MUL_W-1:0] p;
  logic [MUL_W-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;

  // Datapath signals
  logic [MUL_W-1:0]   add_b;
  logic [MUL_W-1:0]   add_sum;
  logic               add_cout;
  logic [2*MUL_W-1:0] p_next;
  logic [CNT_W-1:0]   k;        // step number being executed (cnt+1)
  logic [CNT_W-1:0]   shamt;    // 32-k: alignment shift on early finish
  logic [MUL_W-1:0]   rem_mask; // covers P[31-k:0], the unconsumed multiplier bits
  logic               rem_zero;
  logic               step_done;

  // FSM control
  logic accept;
  logic step;
  logic finish;

  // Adder: a = upper half of P, b = multiplicand gated by current multiplier LSB
  assign add_b = p[0] ? mcand : '0;

  ripple_carry_adder #(.W(MUL_W)) u_adder (
    .a    (p[2*MUL_W-1:MUL_W]),
    .b    (add_b),
    .c0   (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The 65-bit {cout, sum, P[31:0]} shifted right by one
  assign p_next = {add_cout, add_sum, p[MUL_W-1:1]};

  assign k     = cnt + CNT_W'(1);
  assign shamt = CNT_W'(MUL_W) - k;

  // Mask of (32-k) ones; for k=32 it is empty so the check is trivially true
  always_comb begin
    logic [2*MUL_W-1:0] m64;
    m64      = (64'd1 << shamt) - 64'd1;
    rem_mask = m64[MUL_W-1:0];
  end

  assign rem_zero  = ((p_next[MUL_W-1:0] & rem_mask) == '0);
  assign step_done = EARLY_EXIT ? rem_zero : (k == CNT_W'(MUL_W));

  // Next-state / control
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (step_done) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (abort || res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p       <= '0;
      mcand   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (accept) begin
        mcand <= op_a;
        p     <= {{MUL_W{1'b0}}, op_b};
        cnt   <= '0;
      end else if (step) begin
        p   <= p_next;
        cnt <= k;
      end
      // Early finish leaves the product sitting (32-k) bits too high
      if (finish) begin
        product <= p_next >> shamt;
      end
    end
  end

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);

endmodule
